// File: rtl/smoosh_pkg.sv
// Shared constants and the sprite descriptor used by the smoosh video blocks.
package smoosh_pkg;

    localparam int SPR_W = 16;
    localparam int SPR_H = 16;
    localparam logic [5:0] TRANSPARENT = 6'h00;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    // Frame field is sized for up to 16 animation frames; blocks use the low bits.
    localparam int FRAME_FIELD_W = 4;

    typedef struct packed {
        logic [9:0]               x;
        logic [9:0]               y;
        logic [FRAME_FIELD_W-1:0] frame;
        logic                     flip;
        logic                     en;
    } sprite_t;

endpackage

// File: rtl/sprite_hit.sv
// Per-sprite hit test and ROM address generation; outputs are registered (stage 0).
module sprite_hit
    import smoosh_pkg::*;
#(
    parameter int FRAMES = 4,
    parameter int ADDR_W = $clog2(FRAMES * 256)
) (
    input  logic              clk,
    input  logic              rst,
    input  sprite_t           spr,
    input  logic [9:0]        col,
    input  logic [9:0]        row,
    input  logic              valid,
    output logic              hit,
    output logic [ADDR_W-1:0] addr
);

    localparam int FRAME_W = ADDR_W - 8;

    logic [10:0] col_w, row_w, x_w, y_w;
    logic        in_x, in_y;
    logic [3:0]  dx_raw, dx, dy;
    logic        unused_frame_bits;

    // 11-bit compares keep x+16 from wrapping for positions near 1023.
    assign col_w = {1'b0, col};
    assign row_w = {1'b0, row};
    assign x_w   = {1'b0, spr.x};
    assign y_w   = {1'b0, spr.y};

    assign in_x = (col_w >= x_w) && (col_w < x_w + 11'(SPR_W));
    assign in_y = (row_w >= y_w) && (row_w < y_w + 11'(SPR_H));

    assign dx_raw = col[3:0] - spr.x[3:0];
    assign dy     = row[3:0] - spr.y[3:0];
    assign dx     = spr.flip ? (4'd15 - dx_raw) : dx_raw;

    assign unused_frame_bits = ^spr.frame;

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit  <= 1'b0;
            addr <= '0;
        end else begin
            hit  <= spr.en && valid && in_x && in_y;
            addr <= {spr.frame[FRAME_W-1:0], dy, dx};
        end
    end

endmodule

// File: rtl/sprite_overlay.sv
// Composites NUM_SPRITES 16x16 sprites over the background with a fixed 2-cycle latency;
// sprite position updates are double-buffered and committed at the start of vertical blank.
module sprite_overlay
    import smoosh_pkg::*;
#(
    parameter int NUM_SPRITES = 2,
    parameter int FRAMES      = 4,
    parameter int ADDR_W      = $clog2(FRAMES * 256)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     col,
    input  logic [9:0]                     row,
    input  logic                           valid,
    input  logic                           hsync_in,
    input  logic                           vsync_in,
    input  logic [5:0]                     bg_rgb,
    input  logic                           pos_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] pos_id,
    input  logic [9:0]                     pos_x,
    input  logic [9:0]                     pos_y,
    input  logic [$clog2(FRAMES)-1:0]      pos_frame,
    input  logic                           pos_flip,
    input  logic                           pos_en,
    output logic [NUM_SPRITES*ADDR_W-1:0]  spr_addr,
    input  logic [NUM_SPRITES*6-1:0]       spr_data,
    output logic [5:0]                     rgb,
    output logic                           hsync,
    output logic                           vsync
);

    sprite_t pending [NUM_SPRITES];
    sprite_t active  [NUM_SPRITES];
    logic    commit;

    assign commit = (row == 10'(V_VISIBLE)) && (col == 10'd0);

    // NOTE: these arrays are a handful of flops, not a RAM, so they are reset explicitly;
    // a disabled sprite after reset depends on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            // A write on the commit cycle reaches pending only; active takes the old value.
            if (commit) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    active[i] <= pending[i];
                end
            end
            if (pos_we) begin
                pending[pos_id] <= '{x:     pos_x,
                                     y:     pos_y,
                                     frame: FRAME_FIELD_W'(pos_frame),
                                     flip:  pos_flip,
                                     en:    pos_en};
            end
        end
    end

    logic [NUM_SPRITES-1:0] hit_s0, hit_s1;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        sprite_hit #(
            .FRAMES (FRAMES),
            .ADDR_W (ADDR_W)
        ) u_hit (
            .clk   (clk),
            .rst   (rst),
            .spr   (active[g]),
            .col   (col),
            .row   (row),
            .valid (valid),
            .hit   (hit_s0[g]),
            .addr  (spr_addr[g*ADDR_W +: ADDR_W])
        );
    end

    logic       valid_s0, valid_s1;
    logic       hs_s0, hs_s1, vs_s0, vs_s1;
    logic [5:0] bg_s0, bg_s1;

    // Stage 1 lines up with the ROM data returned for the stage-0 address.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s0 <= 1'b0;
            valid_s1 <= 1'b0;
            hs_s0    <= 1'b1;
            hs_s1    <= 1'b1;
            vs_s0    <= 1'b1;
            vs_s1    <= 1'b1;
            bg_s0    <= '0;
            bg_s1    <= '0;
            hit_s1   <= '0;
        end else begin
            valid_s0 <= valid;
            valid_s1 <= valid_s0;
            hs_s0    <= hsync_in;
            hs_s1    <= hs_s0;
            vs_s0    <= vsync_in;
            vs_s1    <= vs_s0;
            bg_s0    <= bg_rgb;
            bg_s1    <= bg_s0;
            hit_s1   <= hit_s0;
        end
    end

    assign hsync = hs_s1;
    assign vsync = vs_s1;

    logic [5:0] rgb_sel;

    // NOTE: combinational logic uses blocking assignments with a default first, so no latch
    // is inferred and later (front) sprites in the loop override earlier (rear) ones.
    always_comb begin
        rgb_sel = bg_s1;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_s1[i] && (spr_data[i*6 +: 6] != TRANSPARENT)) begin
                rgb_sel = spr_data[i*6 +: 6];
            end
        end
        rgb = valid_s1 ? rgb_sel : 6'd0;
    end

endmodule

// File: tb/tb_sprite_overlay.sv
// Self-checking bench for sprite_overlay: directed scenarios plus randomized traffic
// checked against a pixel-level reference model and a synchronous ROM model.
module tb_sprite_overlay;

    localparam int N  = 2;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    col = '0;
    logic [9:0]    row = '0;
    logic          valid = 1'b0;
    logic          hsync_in = 1'b1;
    logic          vsync_in = 1'b1;
    logic [5:0]    bg_rgb = '0;
    logic          pos_we = 1'b0;
    logic [0:0]    pos_id = '0;
    logic [9:0]    pos_x = '0;
    logic [9:0]    pos_y = '0;
    logic [1:0]    pos_frame = '0;
    logic          pos_flip = 1'b0;
    logic          pos_en = 1'b0;
    logic [N*AW-1:0] spr_addr;
    logic [N*6-1:0]  spr_data;
    logic [5:0]    rgb;
    logic          hsync;
    logic          vsync;

    logic [5:0] rom_mem [N][1024];

    typedef struct {
        int x;
        int y;
        int frame;
        bit flip;
        bit en;
    } spr_m_t;

    typedef struct {
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    spr_m_t m_pend [N];
    spr_m_t m_act  [N];
    exp_t   exp_q [$];

    int checks = 0;
    int errors = 0;

    sprite_overlay #(
        .NUM_SPRITES (N),
        .FRAMES      (4),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .valid     (valid),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .bg_rgb    (bg_rgb),
        .pos_we    (pos_we),
        .pos_id    (pos_id),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .pos_frame (pos_frame),
        .pos_flip  (pos_flip),
        .pos_en    (pos_en),
        .spr_addr  (spr_addr),
        .spr_data  (spr_data),
        .rgb       (rgb),
        .hsync     (hsync),
        .vsync     (vsync)
    );

    always #5 clk = ~clk;

    // External synchronous ROM, one read port per sprite, 1-cycle latency.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            spr_data[i*6 +: 6] <= rom_mem[i][spr_addr[i*AW +: AW]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input int i, input int c, input int r);
        return m_act[i].en && (c < 640) && (r < 480) &&
               (c >= m_act[i].x) && (c < m_act[i].x + 16) &&
               (r >= m_act[i].y) && (r < m_act[i].y + 16);
    endfunction

    function automatic int m_addr(input int i, input int c, input int r);
        int u;
        int v;
        u = (c - m_act[i].x) & 15;
        v = (r - m_act[i].y) & 15;
        if (m_act[i].flip) u = 15 - u;
        return m_act[i].frame * 256 + v * 16 + u;
    endfunction

    function automatic logic [5:0] m_pixel(input int c, input int r, input logic [5:0] bg);
        if (!((c < 640) && (r < 480))) return 6'd0;
        for (int i = 0; i < N; i++) begin
            if (m_hit(i, c, r) && (rom_mem[i][m_addr(i, c, r)] != 6'd0))
                return rom_mem[i][m_addr(i, c, r)];
        end
        return bg;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = '{0, 0, 0, 1'b0, 1'b0};
            m_act[i]  = '{0, 0, 0, 1'b0, 1'b0};
        end
    endtask

    task automatic set_px(input int c, input int r);
        col      = 10'(c);
        row      = 10'(r);
        valid    = (c < 640) && (r < 480);
        bg_rgb   = 6'($urandom);
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
    endtask

    task automatic write(input int id, input int x, input int y, input int fr,
                         input bit fl, input bit en);
        pos_we    = 1'b1;
        pos_id    = 1'(id);
        pos_x     = 10'(x);
        pos_y     = 10'(y);
        pos_frame = 2'(fr);
        pos_flip  = fl;
        pos_en    = en;
    endtask

    // One pixel clock: predict, advance the model, clock, then compare.
    task automatic tick();
        int   c;
        int   r;
        int   ea [N];
        exp_t e;
        c = int'(col);
        r = int'(row);
        e.rgb = m_pixel(c, r, bg_rgb);
        e.hs  = hsync_in;
        e.vs  = vsync_in;
        for (int i = 0; i < N; i++) ea[i] = m_addr(i, c, r);
        if (!rst) exp_q.push_back(e);
        if ((r == 480) && (c == 0)) begin
            for (int i = 0; i < N; i++) m_act[i] = m_pend[i];
        end
        if (pos_we)
            m_pend[int'(pos_id)] = '{int'(pos_x), int'(pos_y), int'(pos_frame), pos_flip, pos_en};
        @(posedge clk);
        #1;
        pos_we = 1'b0;
        if (rst) begin
            exp_q.delete();
            model_reset();
            check("reset_rgb", 32'(rgb), 32'd0);
            check("reset_hsync", 32'(hsync), 32'd1);
            check("reset_vsync", 32'(vsync), 32'd1);
            check("reset_addr", 32'(spr_addr), 32'd0);
        end else begin
            for (int i = 0; i < N; i++)
                check("spr_addr", 32'(spr_addr[i*AW +: AW]), 32'(ea[i]));
            if (exp_q.size() == 2) begin
                e = exp_q.pop_front();
                check("rgb", 32'(rgb), 32'(e.rgb));
                check("hsync", 32'(hsync), 32'(e.hs));
                check("vsync", 32'(vsync), 32'(e.vs));
            end
        end
    endtask

    task automatic scan(input int c0, input int c1, input int r0, input int r1);
        for (int r = r0; r <= r1; r++) begin
            for (int c = c0; c <= c1; c++) begin
                set_px(c, r);
                tick();
            end
        end
    endtask

    task automatic do_commit();
        set_px(0, 480);
        tick();
    endtask

    task automatic flush();
        set_px(700, 500);
        tick();
        tick();
        tick();
    endtask

    // Shows pixel (c,r) and returns with rgb holding its composite.
    task automatic probe(input int c, input int r);
        set_px(c, r);
        tick();
        set_px(700, 500);
        tick();
    endtask

    task automatic fill_rom_random();
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < 1024; a++) begin
                rom_mem[i][a] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            end
        end
    endtask

    initial begin
        logic [5:0] bg_keep;
        logic [9:0] exp_addr;
        int         s;
        int         c;
        int         r;

        fill_rom_random();
        rom_mem[0][0] = 6'h2A;
        model_reset();

        // Reset held for 3 cycles with syncs driven low.
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_px(0, 0);
            hsync_in = 1'b0;
            vsync_in = 1'b0;
            tick();
        end
        rst = 1'b0;
        set_px(0, 0);
        bg_rgb = 6'h15;
        tick();
        set_px(700, 500);
        tick();
        check("reset_release_rgb", 32'(rgb), 32'h15);

        // Mid-frame write stays invisible until the commit cycle.
        write(0, 100, 50, 0, 1'b0, 1'b1);
        set_px(320, 200);
        tick();
        set_px(100, 50);
        bg_keep = bg_rgb;
        tick();
        set_px(700, 500);
        tick();
        check("precommit_bg", 32'(rgb), 32'(bg_keep));
        scan(96, 119, 48, 53);
        do_commit();
        scan(96, 119, 48, 53);
        probe(100, 50);
        check("commit_sprite_px", 32'(rgb), 32'h2A);

        // Flip addressing at frame 2.
        write(0, 0, 0, 2, 1'b1, 1'b1);
        set_px(700, 500);
        tick();
        do_commit();
        set_px(0, 0);
        tick();
        exp_addr = {2'd2, 4'd0, 4'd15};
        check("flip_addr_0_0", 32'(spr_addr[AW-1:0]), 32'(exp_addr));
        set_px(15, 3);
        tick();
        exp_addr = {2'd2, 4'd3, 4'd0};
        check("flip_addr_15_3", 32'(spr_addr[AW-1:0]), 32'(exp_addr));
        flush();

        // Priority and transparency with overlapping sprites.
        for (int a = 0; a < 256; a++) begin
            rom_mem[0][a] = 6'h00;
            rom_mem[1][a] = 6'h30;
        end
        write(0, 200, 200, 0, 1'b0, 1'b1);
        set_px(700, 500);
        tick();
        write(1, 200, 200, 0, 1'b0, 1'b1);
        tick();
        do_commit();
        scan(198, 217, 198, 217);
        probe(205, 205);
        check("transparent_front", 32'(rgb), 32'h30);
        flush();
        for (int a = 0; a < 256; a++) rom_mem[0][a] = 6'h0C;
        scan(198, 217, 198, 202);
        probe(205, 205);
        check("front_priority", 32'(rgb), 32'h0C);
        flush();
        fill_rom_random();
        rom_mem[0][0] = 6'h2A;

        // Clipping at the right/bottom edges and fully off-screen.
        write(0, 630, 470, 1, 1'b0, 1'b1);
        set_px(700, 500);
        tick();
        write(1, 640, 100, 3, 1'b1, 1'b1);
        tick();
        do_commit();
        scan(625, 645, 465, 484);
        scan(636, 660, 98, 118);

        // Write landing exactly on the commit cycle.
        write(0, 10, 300, 0, 1'b0, 1'b1);
        set_px(700, 500);
        tick();
        write(1, 0, 0, 0, 1'b0, 1'b0);
        tick();
        do_commit();
        write(0, 300, 300, 0, 1'b0, 1'b1);
        do_commit();
        scan(5, 30, 300, 301);
        scan(295, 320, 300, 301);
        probe(10, 300);
        check("commit_write_old_x", 32'(rgb), 32'h2A);
        do_commit();
        scan(5, 30, 300, 301);
        scan(295, 320, 300, 301);
        probe(300, 300);
        check("commit_write_new_x", 32'(rgb), 32'h2A);
        set_px(10, 300);
        bg_keep = bg_rgb;
        tick();
        set_px(700, 500);
        tick();
        check("commit_write_old_gone", 32'(rgb), 32'(bg_keep));

        // Back-to-back writes to one sprite: the last one wins.
        write(1, 50, 60, 1, 1'b0, 1'b1);
        tick();
        write(1, 70, 80, 3, 1'b1, 1'b1);
        tick();
        do_commit();
        scan(66, 89, 78, 97);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0)
                write($urandom_range(0, N - 1), $urandom_range(0, 700), $urandom_range(0, 500),
                      $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 199) == 0) begin
                set_px(0, 480);
            end else if ($urandom_range(0, 1) == 0) begin
                s = $urandom_range(0, N - 1);
                c = m_act[s].x + $urandom_range(0, 19) - 2;
                r = m_act[s].y + $urandom_range(0, 19) - 2;
                if (c < 0) c = 0;
                if (c > 799) c = 799;
                if (r < 0) r = 0;
                if (r > 524) r = 524;
                set_px(c, r);
            end else begin
                set_px($urandom_range(0, 799), $urandom_range(0, 524));
            end
            tick();
        end

        // Reset in the middle of active video disables every sprite again.
        rst = 1'b1;
        set_px(300, 300);
        tick();
        rst = 1'b0;
        scan(295, 320, 299, 301);
        for (int k = 0; k < 2; k++) do_commit();
        scan(295, 320, 299, 301);
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
